// File: rtl/ef_pwm_deadtime.sv
// Complementary gate driver with programmable dead time and a sticky fault latch.
// Optional macro EF_PWM_DEADTIME_SYNC_EN adds a 2-flop synchronizer on pwm_in/fault_in.
module ef_pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            gate_hi,
    output logic            gate_lo,
    output logic            fault_latched,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_DT_LH,
        S_HI,
        S_DT_HL
    } state_t;

    state_t          r_state;
    logic [DT_W-1:0] r_cnt;
    logic            r_pwm_s;
    logic            r_fault_s;
    logic            w_pwm_pre;
    logic            w_fault_pre;
    logic [DT_W-1:0] w_rise_ld;
    logic [DT_W-1:0] w_fall_ld;

    // A programmed zero still yields one both-low cycle.
    assign w_rise_ld = (dt_rise == '0) ? DT_W'(1) : dt_rise;
    assign w_fall_ld = (dt_fall == '0) ? DT_W'(1) : dt_fall;

`ifdef EF_PWM_DEADTIME_SYNC_EN
    logic [1:0] r_pwm_sync;
    logic [1:0] r_fault_sync;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_pwm_sync   <= '0;
            r_fault_sync <= '0;
        end else begin
            r_pwm_sync   <= {r_pwm_sync[0], pwm_in};
            r_fault_sync <= {r_fault_sync[0], fault_in};
        end
    end

    assign w_pwm_pre   = r_pwm_sync[1];
    assign w_fault_pre = r_fault_sync[1];
`else
    assign w_pwm_pre   = pwm_in;
    assign w_fault_pre = fault_in;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_pwm_s   <= 1'b0;
            r_fault_s <= 1'b0;
        end else begin
            r_pwm_s   <= w_pwm_pre;
            r_fault_s <= w_fault_pre;
        end
    end

    // Outputs default low each edge; only the branch that holds a gate state re-asserts it.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            gate_hi       <= 1'b0;
            gate_lo       <= 1'b0;
            fault_latched <= 1'b0;
            busy          <= 1'b0;
        end else begin
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
            busy    <= 1'b0;
            if (r_fault_s) begin
                fault_latched <= 1'b1;
                r_state       <= S_IDLE;
                r_cnt         <= '0;
            end else begin
                if (fault_clr)
                    fault_latched <= 1'b0;
                if (!en) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (!fault_latched) begin
                                busy <= 1'b1;
                                if (r_pwm_s) begin
                                    r_state <= S_DT_LH;
                                    r_cnt   <= w_rise_ld;
                                end else begin
                                    r_state <= S_DT_HL;
                                    r_cnt   <= w_fall_ld;
                                end
                            end
                        end
                        S_LO: begin
                            if (r_pwm_s) begin
                                r_state <= S_DT_LH;
                                r_cnt   <= w_rise_ld;
                                busy    <= 1'b1;
                            end else begin
                                gate_lo <= 1'b1;
                            end
                        end
                        S_HI: begin
                            if (!r_pwm_s) begin
                                r_state <= S_DT_HL;
                                r_cnt   <= w_fall_ld;
                                busy    <= 1'b1;
                            end else begin
                                gate_hi <= 1'b1;
                            end
                        end
                        S_DT_LH: begin
                            if (!r_pwm_s) begin
                                r_state <= S_LO;
                                r_cnt   <= '0;
                                gate_lo <= 1'b1;
                            end else if (r_cnt <= DT_W'(1)) begin
                                r_state <= S_HI;
                                r_cnt   <= '0;
                                gate_hi <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt - DT_W'(1);
                                busy  <= 1'b1;
                            end
                        end
                        S_DT_HL: begin
                            if (r_pwm_s) begin
                                r_state <= S_HI;
                                r_cnt   <= '0;
                                gate_hi <= 1'b1;
                            end else if (r_cnt <= DT_W'(1)) begin
                                r_state <= S_LO;
                                r_cnt   <= '0;
                                gate_lo <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt - DT_W'(1);
                                busy  <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/ef_pwm_deadtime.md
EF_PWM_DEADTIME -- requirements
Module: ef_pwm_deadtime

Interface
REQ-001 Parameter: DT_W, default 8, width of the dead-time counters and configuration inputs.
REQ-002 Port: PCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: PRESET  input  1  reset, synchronous, active-high.
REQ-004 Port: en  input  1  output-stage enable; 0 forces both gates low.
REQ-005 Port: pwm_in  input  1  raw PWM from the upstream PWM timer (pwmA or pwmB).
REQ-006 Port: dt_rise  input  DT_W  low-to-high dead time in PCLK cycles, applied before gate_hi asserts.
REQ-007 Port: dt_fall  input  DT_W  high-to-low dead time in PCLK cycles, applied before gate_lo asserts.
REQ-008 Port: fault_in  input  1  external fault, active-high.
REQ-009 Port: fault_clr  input  1  single-cycle fault-latch clear request.
REQ-010 Port: gate_hi  output  1  high-side gate drive, registered.
REQ-011 Port: gate_lo  output  1  low-side gate drive, registered.
REQ-012 Port: fault_latched  output  1  sticky fault flag, registered.
REQ-013 Port: busy  output  1  high while a dead-time interval is counting.

Function
REQ-014 pwm_in and fault_in SHALL be registered once (pwm_s, fault_s) before any use.
REQ-015 FSM states: IDLE (both low), LO (gate_lo=1), DT_LH (both low), HI (gate_hi=1), DT_HL (both low); gate_hi and gate_lo SHALL never both be 1 in any cycle.
REQ-016 IDLE -> DT_LH if en & !fault_latched & pwm_s; IDLE -> DT_HL if en & !fault_latched & !pwm_s.
REQ-017 LO & pwm_s -> DT_LH; HI & !pwm_s -> DT_HL; counter loaded on entry with dt_rise or dt_fall respectively.
REQ-018 Dead-time value 0 SHALL be treated as 1; a loaded value N gives exactly max(N,1) cycles with both gates low.
REQ-019 DT_LH with counter expiring -> HI; DT_LH & !pwm_s -> LO immediately (abort, no dead time needed).
REQ-020 DT_HL with counter expiring -> LO; DT_HL & pwm_s -> HI immediately (abort).
REQ-021 dt_rise/dt_fall changes during a running interval SHALL NOT affect that interval; sampled only at load.
REQ-022 Latency: pwm_s change at edge k -> active gate falls at edge k+1 -> opposite gate rises at edge k+1+max(N,1).
REQ-023 busy SHALL equal (state==DT_LH | state==DT_HL).
REQ-024 en=0 from any state -> IDLE at next edge, both gates low that edge.
REQ-025 fault_s=1 SHALL set fault_latched and force IDLE/both gates low at the same edge.
REQ-026 fault_clr clears fault_latched only when fault_s=0; simultaneous fault_s and fault_clr: set wins.
REQ-027 Exit from IDLE after fault clear or re-enable SHALL always pass through a full dead-time state.

Reset
REQ-028 PRESET=1 at a PCLK edge SHALL set state=IDLE, gate_hi=0, gate_lo=0, fault_latched=0, busy=0, counter=0, pwm_s=0, fault_s=0.
REQ-029 Reset asserted mid-dead-time SHALL abort the interval; first post-reset transition obeys REQ-016.

Configuration
REQ-030 Macro EF_PWM_DEADTIME_SYNC_EN: when defined, pwm_in and fault_in SHALL pass through a 2-flop synchronizer before the REQ-014 register, adding 2 cycles to REQ-022 and REQ-025 latency.
REQ-031 Without EF_PWM_DEADTIME_SYNC_EN, only the single REQ-014 register exists; latencies exactly as stated.

Verification (macro undefined unless noted)
REQ-032 en=1, dt_rise=4, pwm_in 0->1 -> gate_lo low 1 cycle after pwm_s, both low 4 cycles, then gate_hi=1; busy high those 4 cycles.
REQ-033 dt_fall=0, pwm_in 1->0 in HI -> both low exactly 1 cycle, then gate_lo=1; never both high.
REQ-034 dt_rise=10, pwm_in high 3 cycles in LO -> DT_LH aborted, gate_lo back to 1, gate_hi never asserts.
REQ-035 fault_in pulse during HI -> both gates low and fault_latched=1 next edge; fault_clr with fault_in=1 ignored; fault_clr after fault_in=0 clears; restart via DT state.
REQ-036 PRESET asserted in DT_HL with dt_fall=20 -> all outputs 0 next edge; after release with pwm_in=0 -> DT_HL full 20 cycles, then gate_lo.
REQ-037 With EF_PWM_DEADTIME_SYNC_EN defined, repeat REQ-032 -> every edge shifted by 2 cycles.
